// File: rtl/uart_tx_queue.sv
// uart_tx_queue
//   Shared transmit FIFO between the switch bank / PS/2 keyboard and the UART.
//   Up to two writes per cycle (switch first, keyboard second), one word
//   drained at a time through a tx_en / tx_busy handshake with a timeout.
//   Optional build macro: KEY_BREAK_FILTER_EN -- strip PS/2 break sequences
//   (0xF0 + next byte) and 0xE0 prefixes so only make codes are enqueued.

module uart_tx_queue #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         sw_data,
    input  logic                      sw_push,
    input  logic [7:0]                key_code,
    input  logic                      key_valid,
    input  logic                      tx_busy,
    output logic                      tx_en,
    output logic [DATA_W-1:0]         tx_data,
    output logic [DATA_W-1:0]         last_sent,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      empty,
    output logic                      full,
    output logic                      overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LAUNCH    = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_empty;
    logic              r_full;
    logic              r_overflow;

    // Drain FSM and output registers
    logic [1:0]        r_state;
    logic [TW-1:0]     r_to_cnt;
    logic              r_tx_en;
    logic [DATA_W-1:0] r_tx_data;
    logic [DATA_W-1:0] r_last_sent;

    // Combinational write/pop decisions
    logic              w_key_req;
    logic [DATA_W-1:0] w_key_word;
    logic [CW-1:0]     w_free;
    logic              w_sw_wr;
    logic              w_key_wr;
    logic              w_drop;
    logic [AW-1:0]     w_key_addr;
    logic [CW-1:0]     w_wr_num;
    logic              w_pop;
    logic [CW-1:0]     w_count_next;

    assign w_key_word = DATA_W'(key_code);

`ifdef KEY_BREAK_FILTER_EN
    logic r_break_pending;

    // Only make codes pass: 0xF0 arms a one-byte discard, 0xE0 is dropped.
    always_comb begin
        w_key_req = key_valid && !r_break_pending
                    && (key_code != 8'hF0) && (key_code != 8'hE0);
    end

    // Break-pending flag follows the keyboard stream, independent of FIFO space.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            r_break_pending <= 1'b0;
        end else if (key_valid) begin
            if (r_break_pending)
                r_break_pending <= 1'b0;
            else if (key_code == 8'hF0)
                r_break_pending <= 1'b1;
        end
    end
`else
    assign w_key_req = key_valid;
`endif

    // Admission: free space comes from the registered count, so a pop in the
    // same cycle never makes room for a write.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        w_free       = CW'(DEPTH) - r_count;
        w_sw_wr      = 1'b0;
        w_key_wr     = 1'b0;
        w_drop       = 1'b0;
        w_key_addr   = r_wr_ptr;
        w_wr_num     = '0;
        w_pop        = 1'b0;
        w_count_next = r_count;

        w_sw_wr  = sw_push && (w_free != '0);
        if (w_sw_wr)
            w_key_wr = w_key_req && (w_free >= CW'(2));
        else
            w_key_wr = w_key_req && (w_free != '0);
        w_drop     = (sw_push && !w_sw_wr) || (w_key_req && !w_key_wr);
        w_key_addr = r_wr_ptr + AW'(w_sw_wr);
        w_wr_num   = CW'(w_sw_wr) + CW'(w_key_wr);

        w_pop        = (r_state == S_IDLE) && !r_empty && !tx_busy;
        w_count_next = r_count + w_wr_num - CW'(w_pop);
    end

    // Storage write: switch word at the tail, keyboard word right behind it.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; pointers and count define
        // which entries are valid, so stale contents are never observed.
        if (w_sw_wr)
            r_mem[r_wr_ptr] <= sw_data;
        if (w_key_wr)
            r_mem[w_key_addr] <= w_key_word;
    end

    // Pointers, occupancy, flags and the sticky overflow bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_wr_num);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= w_count_next;
            r_empty  <= (w_count_next == '0);
            r_full   <= (w_count_next == CW'(DEPTH));
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    // Drain FSM: pop on the edge into LAUNCH, then wait for the UART
    // to accept (busy high) and finish (busy low), or give up on timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_to_cnt    <= '0;
            r_tx_en     <= 1'b0;
            r_tx_data   <= '0;
            r_last_sent <= '0;
        end else begin
            r_tx_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state     <= S_LAUNCH;
                        r_tx_en     <= 1'b1;
                        r_tx_data   <= r_mem[r_rd_ptr];
                        r_last_sent <= r_mem[r_rd_ptr];
                    end
                end
                S_LAUNCH: begin
                    r_state  <= S_WAIT_BUSY;
                    r_to_cnt <= '0;
                end
                S_WAIT_BUSY: begin
                    if (tx_busy)
                        r_state <= S_WAIT_DONE;
                    else if (r_to_cnt == TW'(ACK_TIMEOUT - 1))
                        r_state <= S_IDLE;
                    else
                        r_to_cnt <= r_to_cnt + 1'b1;
                end
                S_WAIT_DONE: begin
                    if (!tx_busy)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx_en      = r_tx_en;
    assign tx_data    = r_tx_data;
    assign last_sent  = r_last_sent;
    assign fifo_count = r_count;
    assign empty      = r_empty;
    assign full       = r_full;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue
//   Directed scenarios plus a randomized phase. A queue-based reference model
//   decides which words are admitted and in what order they must leave; a
//   small UART model drives tx_busy. Honours KEY_BREAK_FILTER_EN if defined.

module tb_uart_tx_queue;

    localparam int DATA_W      = 8;
    localparam int DEPTH       = 16;
    localparam int ACK_TIMEOUT = 40;
    localparam int CW          = $clog2(DEPTH) + 1;

    localparam int M_NORMAL = 0;
    localparam int M_HOLD   = 1;
    localparam int M_NEVER  = 2;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] sw_data;
    logic              sw_push;
    logic [7:0]        key_code;
    logic              key_valid;
    logic              tx_busy;
    logic              tx_en;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] last_sent;
    logic [CW-1:0]     fifo_count;
    logic              empty;
    logic              full;
    logic              overflow;

    uart_tx_queue #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_data    (sw_data),
        .sw_push    (sw_push),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .tx_busy    (tx_busy),
        .tx_en      (tx_en),
        .tx_data    (tx_data),
        .last_sent  (last_sent),
        .fifo_count (fifo_count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [DATA_W-1:0] mq[$];          // words admitted, not yet launched
    logic [DATA_W-1:0] launch_log[$];  // words launched, in order
    bit                m_ovf;
    bit                m_brk;
    logic [DATA_W-1:0] m_tx;
    logic [DATA_W-1:0] m_last;
    int                cyc;
    int                last_launch;
    int                gap;

    // UART model state
    int mode;
    int busy_left;
    int frame_min;
    int frame_max;

    // One clock: apply model rules at the edge, then compare all outputs.
    task automatic tick();
        bit busy_before;
        int pre;
        int free;
        bit sw_acc;
        bit key_req;
        bit key_acc;
        busy_before = tx_busy;
        pre = 0;
        @(posedge clk);
        cyc++;
        if (reset) begin
            mq.delete();
            m_ovf  = 0;
            m_brk  = 0;
            m_tx   = '0;
            m_last = '0;
        end else begin
            pre  = mq.size();
            free = DEPTH - pre;
            key_req = key_valid;
`ifdef KEY_BREAK_FILTER_EN
            if (key_valid) begin
                if (m_brk) begin
                    key_req = 0;
                    m_brk   = 0;
                end else if (key_code == 8'hF0) begin
                    key_req = 0;
                    m_brk   = 1;
                end else if (key_code == 8'hE0) begin
                    key_req = 0;
                end
            end
`endif
            sw_acc  = sw_push && (free >= 1);
            key_acc = key_req && (free >= (sw_acc ? 2 : 1));
            if ((sw_push && !sw_acc) || (key_req && !key_acc))
                m_ovf = 1;
            if (sw_acc)
                mq.push_back(sw_data);
            if (key_acc)
                mq.push_back(DATA_W'(key_code));
        end
        #1;
        sw_push   = 1'b0;
        key_valid = 1'b0;
        if (tx_en === 1'b1) begin
            if (reset || pre == 0) begin
                check("spurious_tx_en", tx_en, 0);
            end else begin
                m_tx   = mq.pop_front();
                m_last = m_tx;
                launch_log.push_back(m_tx);
                check("launch_busy_low", busy_before, 0);
                check("launch_spacing", (cyc - last_launch) >= 4, 1);
                gap         = cyc - last_launch;
                last_launch = cyc;
            end
        end
        check("fifo_count", fifo_count, mq.size());
        check("empty", empty, mq.size() == 0);
        check("full", full, mq.size() == DEPTH);
        check("overflow", overflow, m_ovf);
        check("tx_data", tx_data, m_tx);
        check("last_sent", last_sent, m_last);
        // UART model
        case (mode)
            M_HOLD:  tx_busy = 1'b1;
            M_NEVER: tx_busy = 1'b0;
            default: begin
                if (tx_en === 1'b1)
                    busy_left = $urandom_range(frame_max, frame_min);
                if (busy_left > 0) begin
                    tx_busy = 1'b1;
                    busy_left--;
                end else begin
                    tx_busy = 1'b0;
                end
            end
        endcase
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((mq.size() != 0 || tx_busy || busy_left != 0) && n < 2000) begin
            tick();
            n++;
        end
        tick();
        tick();
        check(tag, fifo_count, 0);
    endtask

    task automatic push_sw(input logic [DATA_W-1:0] d);
        sw_data = d;
        sw_push = 1'b1;
    endtask

    task automatic push_key(input logic [7:0] k);
        key_code  = k;
        key_valid = 1'b1;
    endtask

    logic [DATA_W-1:0] words [17];
    logic [7:0]        keys  [5];
    logic [DATA_W-1:0] exp_brk[$];
    int                t0;

    initial begin
        reset = 1'b1; sw_data = '0; sw_push = 1'b0; key_code = '0; key_valid = 1'b0;
        tx_busy = 1'b0;
        m_ovf = 0; m_brk = 0; m_tx = '0; m_last = '0; cyc = 0; last_launch = -100; gap = 0;
        mode = M_NORMAL; busy_left = 0; frame_min = 1; frame_max = 4;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        check("rst_tx_en", tx_en, 0);
        check("rst_empty", empty, 1);
        check("rst_count", fifo_count, 0);

        // Enqueue-to-launch latency
        push_sw(8'hA5);
        tick();
        check("lat_n_tx_en", tx_en, 0);
        check("lat_n_count", fifo_count, 1);
        tick();
        check("lat_n1_tx_en", tx_en, 1);
        check("lat_tx_data", tx_data, 8'hA5);
        check("lat_last_sent", last_sent, 8'hA5);
        check("lat_count", fifo_count, 0);
        drain("drain_lat");

        // Simultaneous switch + key: switch first
        launch_log.delete();
        push_sw(8'h12);
        push_key(8'h1C);
        tick();
        check("pair_count", fifo_count, 2);
        drain("drain_pair");
        check("pair_n", launch_log.size(), 2);
        if (launch_log.size() >= 2) begin
            check("pair_first", launch_log[0], 8'h12);
            check("pair_second", launch_log[1], 8'h1C);
        end

        // Offset pointers, then fill past capacity with the UART held busy
        for (int i = 0; i < 3; i++) begin
            push_sw(DATA_W'($urandom));
            tick();
        end
        drain("drain_offset");
        mode = M_HOLD;
        tx_busy = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) begin
            words[i] = DATA_W'($urandom);
            push_sw(words[i]);
            tick();
        end
        check("fill_full", full, 1);
        check("fill_count", fifo_count, DEPTH);
        check("fill_overflow", overflow, 1);
        launch_log.delete();
        mode = M_NORMAL;
        drain("drain_fill");
        check("fill_n", launch_log.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++)
            if (i < launch_log.size())
                check("fill_order", launch_log[i], words[i]);

        // Reset while a frame is in flight and three words wait
        frame_min = 10; frame_max = 10;
        launch_log.delete();
        push_sw(8'h31); push_key(8'h32);
        tick();
        push_sw(8'h33); push_key(8'h34);
        tick();
        tick(); tick(); tick();
        check("pre_rst_count", fifo_count, 3);
        check("pre_rst_busy", tx_busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_overflow", overflow, 0);
        launch_log.delete();
        for (int i = 0; i < 20; i++)
            tick();
        check("mid_rst_no_launch", launch_log.size(), 0);
        frame_min = 1; frame_max = 4;

        // UART never answers: handshake abandoned after the timeout
        mode = M_NEVER;
        launch_log.delete();
        push_sw(8'h41); push_key(8'h42);
        tick();
        t0 = 0;
        while (launch_log.size() < 1 && t0 < 20) begin tick(); t0++; end
        t0 = 0;
        while (launch_log.size() < 2 && t0 < 3 * ACK_TIMEOUT) begin tick(); t0++; end
        check("timeout_n", launch_log.size(), 2);
        check("timeout_gap_ok", (gap >= ACK_TIMEOUT + 1) && (gap <= ACK_TIMEOUT + 3), 1);
        if (launch_log.size() >= 2)
            check("timeout_second", launch_log[1], 8'h42);
        for (int i = 0; i < ACK_TIMEOUT + 4; i++)
            tick();
        mode = M_NORMAL;

        // Keyboard stream with break and extended prefixes
        keys[0] = 8'h1C; keys[1] = 8'hF0; keys[2] = 8'h1C; keys[3] = 8'hE0; keys[4] = 8'h75;
`ifdef KEY_BREAK_FILTER_EN
        exp_brk.push_back(8'h1C); exp_brk.push_back(8'h75);
`else
        for (int i = 0; i < 5; i++) exp_brk.push_back(keys[i]);
`endif
        launch_log.delete();
        for (int i = 0; i < 5; i++) begin
            push_key(keys[i]);
            tick();
        end
        drain("drain_brk");
        check("brk_n", launch_log.size(), exp_brk.size());
        for (int i = 0; i < exp_brk.size(); i++)
            if (i < launch_log.size())
                check("brk_order", launch_log[i], exp_brk[i]);

        // Randomized traffic with occasional busy stalls to force overflow
        frame_min = 1; frame_max = 6;
        for (int i = 0; i < 1500; i++) begin
            if ((i % 200) == 100) mode = M_HOLD;
            if ((i % 200) == 140) mode = M_NORMAL;
            if ($urandom_range(3, 0) == 0)
                push_sw(DATA_W'($urandom));
            if ($urandom_range(3, 0) == 0) begin
                case ($urandom_range(7, 0))
                    0:       push_key(8'hF0);
                    1:       push_key(8'hE0);
                    default: push_key(8'($urandom));
                endcase
            end
            tick();
        end
        mode = M_NORMAL;
        drain("drain_rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Parametrised transmit front end between the user inputs (switch bank with push button, PS/2 keyboard decoder) and the UART transmitter. Switch and keyboard bytes are captured into a shared FIFO and drained to the UART one word at a time through an enable/busy handshake, so key bursts and fast button presses are not lost while a frame is in flight. Status outputs (occupancy, last word sent, overflow) feed the seven-segment display logic.

## Interface
- `DATA_W`, 8: transmit word width, ≥ 8; keycodes are zero-extended to `DATA_W`.
- `DEPTH`, 16: FIFO entries; a power of two, 2..256.
- `ACK_TIMEOUT`, 1023: cycles to wait for `tx_busy` to rise after a launch before abandoning the handshake.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sw_data`  in  DATA_W  switch word, sampled on `sw_push`.
- `sw_push`  in  1  one-cycle pulse from the button single-pulser.
- `key_code`  in  8  PS/2 scan code.
- `key_valid`  in  1  one-cycle strobe qualifying `key_code`.
- `tx_busy`  in  1  UART transmitter busy.
- `tx_en`  out  1  one-cycle launch pulse to the UART.
- `tx_data`  out  DATA_W  word being sent; held stable between launches.
- `last_sent`  out  DATA_W  copy of the most recently launched word, for display.
- `fifo_count`  out  $clog2(DEPTH)+1  current occupancy.
- `empty`, `full`  out  1 each  FIFO flags.
- `overflow`  out  1  sticky; set when any write is dropped.

## Operation
- Two write sources per cycle: switch (priority 1), keyboard (priority 2). Both present with ≥ 2 free slots: switch word written first, key second, count +2.
- Exactly 1 free slot with both present: switch written, key dropped, `overflow` set. No free slot: all writes dropped, `overflow` set.
- Free slots evaluated from the count at the start of the cycle; a pop in the same cycle does not free a slot until the next cycle.
- Pointers wrap modulo `DEPTH`; `fifo_count` ranges 0..DEPTH.
- Drain FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - IDLE → LAUNCH when `!empty && !tx_busy`.
  - LAUNCH (one cycle): `tx_en`=1, head popped into `tx_data` and `last_sent`; → WAIT_BUSY.
  - WAIT_BUSY: → WAIT_DONE when `tx_busy`=1; → IDLE after `ACK_TIMEOUT` cycles without `tx_busy` (word counts as sent, not retried).
  - WAIT_DONE: → IDLE when `tx_busy`=0.
- `overflow` clears only on `reset`.
- `reset` mid-operation: FIFO emptied, FSM to IDLE, any in-flight UART frame is ignored; no `tx_en` in the reset cycle or the cycle after.

## Timing
- Reset values: `tx_en`=0, `tx_data`=0, `last_sent`=0, `fifo_count`=0, `empty`=1, `full`=0, `overflow`=0, FSM=IDLE.
- Write at edge N visible in `fifo_count`/`empty` after edge N; earliest `tx_en` from an empty queue is the cycle after edge N+1 (2-cycle enqueue-to-launch latency).
- `tx_data` changes only on the edge entering LAUNCH; valid in the same cycle `tx_en` is high.
- Minimum launch spacing: 4 cycles (LAUNCH, WAIT_BUSY ≥ 1, WAIT_DONE ≥ 1, IDLE).
- All outputs registered; no combinational input-to-output paths.

## Configuration
- `KEY_BREAK_FILTER_EN` defined: keyboard byte 0xF0 is not enqueued and arms a break-pending flag; the next `key_valid` byte is discarded and clears the flag; byte 0xE0 is discarded and leaves the flag unchanged. Only make codes reach the FIFO. Flag clears on `reset`.
- Not defined: every `key_valid` byte is enqueued raw, including 0xF0 and 0xE0.

## Test plan
- Reset, then `sw_data`=0xA5 with `sw_push` while `tx_busy`=0 -> `tx_en` pulse two cycles later with `tx_data`=0xA5, `last_sent`=0xA5, `fifo_count` back to 0.
- `sw_push` (0x12) and `key_valid` (0x1C) in the same cycle with empty FIFO -> `fifo_count`=2; launches in order 0x12 then 0x1C, each after the UART model drops `tx_busy`.
- Hold `tx_busy`=1, write 17 words with DEPTH=16 -> `full`=1, `fifo_count`=16, `overflow`=1; release busy -> exactly the first 16 words launched in order across pointer wrap.
- With `KEY_BREAK_FILTER_EN`: key stream 0x1C, 0xF0, 0x1C, 0xE0, 0x75 -> only 0x1C and 0x75 sent; without the macro all five sent.
- UART model never asserts `tx_busy` -> FSM returns to IDLE after `ACK_TIMEOUT` cycles and launches the next queued word.
- Assert `reset` in WAIT_DONE with 3 words queued -> next cycle `fifo_count`=0, `empty`=1, `overflow`=0; no further `tx_en`.
